// File: rtl/pol_ofm_dispatch.sv
// -----------------------------------------------------------------------------
// pol_ofm_dispatch
//
// Return path of the pool-core memory interface. Takes the tagged
// output-feature-map stream, {port tag, DAT_WIDTH data} per beat, and steers
// each beat into a small first-word-fall-through buffer owned by the pool
// core named in the tag. A stalled core only back-pressures beats that carry
// its own tag. Per-core outstanding-request counters track address requests
// against returned beats, and protocol errors are latched into DSP_Err.
//
// Optional build feature:
//   DSP_STALL_CNT_EN  When defined, DSP_StallCnt counts the cycles in which a
//                     valid input beat is refused (16-bit, saturating).
//                     When undefined, DSP_StallCnt is tied to zero.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   MICDSP_Ofm      tagged input beat, tag in the MSBs
//   MICDSP_OfmVld   input beat valid
//   DSPMIC_OfmRdy   input beat ready (combinational on tag and full flags)
//   POLDSP_ReqFire  per-core pulse: one address request issued this cycle
//   DSPPOL_Ofm      per-core head data, core i at [DAT_WIDTH*i +: DAT_WIDTH]
//   DSPPOL_OfmVld   per-core head valid
//   POLDSP_OfmRdy   per-core pop
//   DSP_Err         sticky: [0] tag out of range, [1] beat with nothing
//                   outstanding, [2] outstanding counter overflow
//   DSP_Idle        all buffers empty and all outstanding counters zero
//   DSP_StallCnt    refused-beat cycle counter (see above)
// -----------------------------------------------------------------------------
module pol_ofm_dispatch #(
  parameter int  POOL_CORE      = 6,
  parameter int  POOL_COMP_CORE = 64,
  parameter int  ACT_WIDTH      = 8,
  parameter int  BUF_DEPTH      = 2,
  parameter int  OUT_WIDTH      = 4,
  localparam int PORT_WIDTH     = $clog2(POOL_CORE),
  localparam int DAT_WIDTH      = ACT_WIDTH * POOL_COMP_CORE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORT_WIDTH+DAT_WIDTH-1:0] MICDSP_Ofm,
  input  logic                            MICDSP_OfmVld,
  output logic                            DSPMIC_OfmRdy,
  input  logic [POOL_CORE-1:0]            POLDSP_ReqFire,
  output logic [DAT_WIDTH*POOL_CORE-1:0]  DSPPOL_Ofm,
  output logic [POOL_CORE-1:0]            DSPPOL_OfmVld,
  input  logic [POOL_CORE-1:0]            POLDSP_OfmRdy,
  output logic [2:0]                      DSP_Err,
  output logic                            DSP_Idle,
  output logic [15:0]                     DSP_StallCnt
);

  localparam int                    AW        = $clog2(BUF_DEPTH);
  localparam logic [PORT_WIDTH:0]   NUM_CORES = (PORT_WIDTH + 1)'(POOL_CORE);
  localparam logic [OUT_WIDTH-1:0]  CNT_MAX   = '1;

  // Input decode
  logic [PORT_WIDTH-1:0] tag;
  logic                  tag_ok;
  logic                  in_rdy;
  logic                  accept;

  // Per-core buffer control
  logic [POOL_CORE-1:0]  full;
  logic [POOL_CORE-1:0]  empty;
  logic [POOL_CORE-1:0]  push;
  logic [POOL_CORE-1:0]  pop;

  // Pointers carry one wrap bit above the entry index.
  logic [AW:0]           wr_ptr_q [POOL_CORE];
  logic [AW:0]           wr_ptr_d [POOL_CORE];
  logic [AW:0]           rd_ptr_q [POOL_CORE];
  logic [AW:0]           rd_ptr_d [POOL_CORE];

  logic [OUT_WIDTH-1:0]  cnt_q    [POOL_CORE];
  logic [OUT_WIDTH-1:0]  cnt_d    [POOL_CORE];

  logic [DAT_WIDTH-1:0]  mem_q    [POOL_CORE][BUF_DEPTH];

  logic [2:0]            err_q, err_d;
  logic                  idle_q, idle_d;

  // ---------------------------------------------------------------------------
  // Buffer status from the registered pointers only.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < POOL_CORE; i++) begin
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Tag decode and input ready. An out-of-range tag is always accepted so the
  // beat can be dropped instead of wedging the upstream FIFO. Ready ignores
  // same-cycle pops, so a full buffer reopens one cycle after it is popped.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    tag    = MICDSP_Ofm[PORT_WIDTH+DAT_WIDTH-1:DAT_WIDTH];
    tag_ok = ({1'b0, tag} < NUM_CORES);
    in_rdy = 1'b1;
    for (int i = 0; i < POOL_CORE; i++) begin
      if (tag == PORT_WIDTH'(i)) in_rdy = !full[i];
    end
    accept = MICDSP_OfmVld && in_rdy;
  end

  // ---------------------------------------------------------------------------
  // Next-state: pointers, outstanding counters, error flags, idle.
  // A request and a returned beat for the same core in one cycle cancel, so
  // neither the zero-outstanding nor the overflow error can fire in that case.
  // ---------------------------------------------------------------------------
  always_comb begin
    err_d  = err_q;
    idle_d = 1'b1;

    if (accept && !tag_ok) err_d[0] = 1'b1;

    for (int i = 0; i < POOL_CORE; i++) begin
      push[i]     = accept && (tag == PORT_WIDTH'(i));
      pop[i]      = !empty[i] && POLDSP_OfmRdy[i];
      wr_ptr_d[i] = wr_ptr_q[i] + (AW + 1)'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + (AW + 1)'(pop[i]);

      cnt_d[i] = cnt_q[i];
      if (POLDSP_ReqFire[i] && !push[i]) begin
        if (cnt_q[i] == CNT_MAX) err_d[2] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (push[i] && !POLDSP_ReqFire[i]) begin
        // The beat is still delivered; only the bookkeeping is off.
        if (cnt_q[i] == '0) err_d[1] = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end

      if ((wr_ptr_d[i] != rd_ptr_d[i]) || (cnt_d[i] != '0)) idle_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < POOL_CORE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      err_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < POOL_CORE; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      err_q  <= err_d;
      idle_q <= idle_d;
    end
  end

  // NOTE: the buffer storage has no reset; a cleared pointer pair already
  // marks every entry empty, and the outputs below are masked while empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < POOL_CORE; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= MICDSP_Ofm[DAT_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Head data is forced to zero while a buffer is empty so stale
  // storage never shows on the port.
  // ---------------------------------------------------------------------------
  always_comb begin
    DSPPOL_Ofm = '0;
    for (int i = 0; i < POOL_CORE; i++) begin
      if (!empty[i]) DSPPOL_Ofm[DAT_WIDTH*i +: DAT_WIDTH] = mem_q[i][rd_ptr_q[i][AW-1:0]];
    end
  end

  assign DSPMIC_OfmRdy = in_rdy;
  assign DSPPOL_OfmVld = ~empty;
  assign DSP_Err       = err_q;
  assign DSP_Idle      = idle_q;

`ifdef DSP_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (MICDSP_OfmVld && !in_rdy && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign DSP_StallCnt = stall_cnt_q;
`else
  assign DSP_StallCnt = '0;
`endif

endmodule

// File: tb/tb_pol_ofm_dispatch.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pol_ofm_dispatch (default parameters).
// Directed table of per-cycle vectors, hand-written corner sequences, then a
// randomized run checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pol_ofm_dispatch;

  localparam int PC   = 6;
  localparam int PW   = 3;
  localparam int DW   = 512;
  localparam int BD   = 2;
  localparam int CMAX = 15;
`ifdef DSP_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [PW+DW-1:0]  MICDSP_Ofm;
  logic              MICDSP_OfmVld;
  logic              DSPMIC_OfmRdy;
  logic [PC-1:0]     POLDSP_ReqFire;
  logic [DW*PC-1:0]  DSPPOL_Ofm;
  logic [PC-1:0]     DSPPOL_OfmVld;
  logic [PC-1:0]     POLDSP_OfmRdy;
  logic [2:0]        DSP_Err;
  logic              DSP_Idle;
  logic [15:0]       DSP_StallCnt;

  pol_ofm_dispatch dut (
    .clk            (clk),
    .rst            (rst),
    .MICDSP_Ofm     (MICDSP_Ofm),
    .MICDSP_OfmVld  (MICDSP_OfmVld),
    .DSPMIC_OfmRdy  (DSPMIC_OfmRdy),
    .POLDSP_ReqFire (POLDSP_ReqFire),
    .DSPPOL_Ofm     (DSPPOL_Ofm),
    .DSPPOL_OfmVld  (DSPPOL_OfmVld),
    .POLDSP_OfmRdy  (POLDSP_OfmRdy),
    .DSP_Err        (DSP_Err),
    .DSP_Idle       (DSP_Idle),
    .DSP_StallCnt   (DSP_StallCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well away from the rising edge that commits the cycle.
  task automatic drive(input logic vld, input logic [PW-1:0] tag, input logic [DW-1:0] dat,
                       input logic [PC-1:0] req, input logic [PC-1:0] ordy);
    @(negedge clk);
    MICDSP_OfmVld  = vld;
    MICDSP_Ofm     = {tag, dat};
    POLDSP_ReqFire = req;
    POLDSP_OfmRdy  = ordy;
    #1;
  endtask

  task automatic idle_cycle(input logic [PC-1:0] ordy);
    drive(1'b0, '0, '0, '0, ordy);
  endtask

  task automatic reset_dut();
    rst            = 1'b1;
    MICDSP_OfmVld  = 1'b0;
    MICDSP_Ofm     = '0;
    POLDSP_ReqFire = '0;
    POLDSP_OfmRdy  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per cycle. Expected values are what the
  // outputs show during that cycle, before its rising edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          vld;
    logic [PW-1:0] tag;
    logic [7:0]    dat;
    logic [PC-1:0] req;
    logic [PC-1:0] ordy;
    logic          exp_rdy;
    logic [PC-1:0] exp_vld;
    int            chk_core;
    logic [7:0]    exp_head;
    logic [2:0]    exp_err;
    logic          exp_idle;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic vld, logic [PW-1:0] tag, logic [7:0] dat, logic [PC-1:0] req,
                              logic [PC-1:0] ordy, logic erdy, logic [PC-1:0] evld, int chk,
                              logic [7:0] ehead, logic [2:0] eerr, logic eidle);
    vec_t v;
    v.vld = vld; v.tag = tag; v.dat = dat; v.req = req; v.ordy = ordy;
    v.exp_rdy = erdy; v.exp_vld = evld; v.chk_core = chk; v.exp_head = ehead;
    v.exp_err = eerr; v.exp_idle = eidle;
    return v;
  endfunction

  // Reference model state for the random phase
  logic [DW-1:0] mq [PC][$];
  int            mcnt [PC];
  logic [2:0]    merr;
  logic          midle;
  int            mstall;

  initial begin
    // Core 2: three requests, three beats, core always ready.
    vecs[0]  = mk(0, 0, 8'h00, 6'b000100, 6'h3F, 1, 6'b000000, -1, 8'h00, 3'b000, 1);
    vecs[1]  = mk(0, 0, 8'h00, 6'b000100, 6'h3F, 1, 6'b000000, -1, 8'h00, 3'b000, 0);
    vecs[2]  = mk(0, 0, 8'h00, 6'b000100, 6'h3F, 1, 6'b000000, -1, 8'h00, 3'b000, 0);
    vecs[3]  = mk(1, 2, 8'hA1, 6'b000000, 6'h3F, 1, 6'b000000, -1, 8'h00, 3'b000, 0);
    vecs[4]  = mk(1, 2, 8'hA2, 6'b000000, 6'h3F, 1, 6'b000100,  2, 8'hA1, 3'b000, 0);
    vecs[5]  = mk(1, 2, 8'hA3, 6'b000000, 6'h3F, 1, 6'b000100,  2, 8'hA2, 3'b000, 0);
    vecs[6]  = mk(0, 0, 8'h00, 6'b000000, 6'h3F, 1, 6'b000100,  2, 8'hA3, 3'b000, 0);
    vecs[7]  = mk(0, 0, 8'h00, 6'b000000, 6'h3F, 1, 6'b000000, -1, 8'h00, 3'b000, 1);
    // Core 1 blocked with depth 2, then a beat for core 4 behind it.
    vecs[8]  = mk(0, 0, 8'h00, 6'b010010, 6'h00, 1, 6'b000000, -1, 8'h00, 3'b000, 1);
    vecs[9]  = mk(0, 0, 8'h00, 6'b000010, 6'h00, 1, 6'b000000, -1, 8'h00, 3'b000, 0);
    vecs[10] = mk(0, 0, 8'h00, 6'b000010, 6'h00, 1, 6'b000000, -1, 8'h00, 3'b000, 0);
    vecs[11] = mk(1, 1, 8'hB1, 6'b000000, 6'h00, 1, 6'b000000, -1, 8'h00, 3'b000, 0);
    vecs[12] = mk(1, 1, 8'hB2, 6'b000000, 6'h00, 1, 6'b000010,  1, 8'hB1, 3'b000, 0);
    vecs[13] = mk(1, 1, 8'hB3, 6'b000000, 6'h00, 0, 6'b000010,  1, 8'hB1, 3'b000, 0);
    vecs[14] = mk(1, 1, 8'hB3, 6'b000000, 6'h02, 0, 6'b000010,  1, 8'hB1, 3'b000, 0);
    vecs[15] = mk(1, 1, 8'hB3, 6'b000000, 6'h00, 1, 6'b000010,  1, 8'hB2, 3'b000, 0);
    vecs[16] = mk(1, 4, 8'hC4, 6'b000000, 6'h00, 1, 6'b000010,  1, 8'hB2, 3'b000, 0);
    vecs[17] = mk(0, 0, 8'h00, 6'b000000, 6'h00, 1, 6'b010010,  4, 8'hC4, 3'b000, 0);
    vecs[18] = mk(0, 0, 8'h00, 6'b000000, 6'h12, 1, 6'b010010,  1, 8'hB2, 3'b000, 0);
    vecs[19] = mk(0, 0, 8'h00, 6'b000000, 6'h02, 1, 6'b000010,  1, 8'hB3, 3'b000, 0);
    vecs[20] = mk(0, 0, 8'h00, 6'b000000, 6'h00, 1, 6'b000000, -1, 8'h00, 3'b000, 1);

    // ---- Reset state ---------------------------------------------------------
    reset_dut();
    #1;
    check("rst_rdy",   64'(DSPMIC_OfmRdy), 64'd1);
    check("rst_vld",   64'(DSPPOL_OfmVld), 64'd0);
    check("rst_ofm",   64'(|DSPPOL_Ofm),   64'd0);
    check("rst_err",   64'(DSP_Err),       64'd0);
    check("rst_idle",  64'(DSP_Idle),      64'd1);
    check("rst_stall", 64'(DSP_StallCnt),  64'd0);

    // ---- Directed table ------------------------------------------------------
    for (int r = 0; r < NV; r++) begin
      drive(vecs[r].vld, vecs[r].tag, DW'(vecs[r].dat), vecs[r].req, vecs[r].ordy);
      check($sformatf("vec%0d_rdy", r),  64'(DSPMIC_OfmRdy), 64'(vecs[r].exp_rdy));
      check($sformatf("vec%0d_vld", r),  64'(DSPPOL_OfmVld), 64'(vecs[r].exp_vld));
      check($sformatf("vec%0d_err", r),  64'(DSP_Err),       64'(vecs[r].exp_err));
      check($sformatf("vec%0d_idle", r), 64'(DSP_Idle),      64'(vecs[r].exp_idle));
      if (vecs[r].chk_core >= 0)
        check_dat($sformatf("vec%0d_head", r), DSPPOL_Ofm[DW*vecs[r].chk_core +: DW],
                  DW'(vecs[r].exp_head));
    end

    // ---- Out-of-range tag is accepted and dropped ----------------------------
    reset_dut();
    drive(1'b1, 3'd7, DW'(8'h77), '0, 6'h3F);
    check("tag7_rdy", 64'(DSPMIC_OfmRdy), 64'd1);
    idle_cycle(6'h3F);
    check("tag7_vld",  64'(DSPPOL_OfmVld), 64'd0);
    check("tag7_err",  64'(DSP_Err),       64'b001);
    check("tag7_idle", 64'(DSP_Idle),      64'd1);
    idle_cycle(6'h3F);
    check("tag7_vld2", 64'(DSPPOL_OfmVld), 64'd0);

    // ---- Beat with nothing outstanding ---------------------------------------
    reset_dut();
    drive(1'b1, 3'd0, DW'(8'h5A), '0, 6'h00);
    idle_cycle(6'h00);
    check("zero_vld",  64'(DSPPOL_OfmVld), 64'b000001);
    check_dat("zero_head", DSPPOL_Ofm[0 +: DW], DW'(8'h5A));
    check("zero_err",  64'(DSP_Err),       64'b010);
    check("zero_idle", 64'(DSP_Idle),      64'd0);
    idle_cycle(6'h01);
    idle_cycle(6'h01);
    check("zero_vld_after", 64'(DSPPOL_OfmVld), 64'd0);
    check("zero_cnt_stays", 64'(DSP_Idle),      64'd1);

    // ---- Outstanding counter saturation on core 3 ----------------------------
    reset_dut();
    for (int k = 0; k < 16; k++) drive(1'b0, '0, '0, 6'b001000, 6'h3F);
    idle_cycle(6'h3F);
    check("sat_err", 64'(DSP_Err), 64'b100);
    // Saturated at 15: fifteen beats are matched, the sixteenth is not.
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 3'd3, DW'(k), '0, 6'h3F);
      check($sformatf("sat_rdy%0d", k), 64'(DSPMIC_OfmRdy), 64'd1);
    end
    idle_cycle(6'h3F);
    idle_cycle(6'h3F);
    check("sat_err_15", 64'(DSP_Err),  64'b100);
    check("sat_idle",   64'(DSP_Idle), 64'd1);
    drive(1'b1, 3'd3, DW'(8'hEE), '0, 6'h3F);
    idle_cycle(6'h3F);
    check("sat_err_16", 64'(DSP_Err), 64'b110);

    // ---- Stall counter: beat blocked for 20 cycles ---------------------------
    reset_dut();
    drive(1'b1, 3'd5, DW'(8'h01), '0, 6'h00);
    drive(1'b1, 3'd5, DW'(8'h02), '0, 6'h00);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 3'd5, DW'(8'h03), '0, 6'h00);
      check($sformatf("stall_rdy%0d", k), 64'(DSPMIC_OfmRdy), 64'd0);
    end
    idle_cycle(6'h00);
    check("stall_cnt", 64'(DSP_StallCnt), STALL_EN ? 64'd20 : 64'd0);
    check("stall_other_tag_rdy", 64'(DSPMIC_OfmRdy), 64'd1);

    // ---- Asynchronous reset with core 5 holding data -------------------------
    check("pre_rst_vld", 64'(DSPPOL_OfmVld), 64'b100000);
    #2 rst = 1'b1;
    #1;
    check("arst_vld",   64'(DSPPOL_OfmVld), 64'd0);
    check("arst_ofm",   64'(|DSPPOL_Ofm),   64'd0);
    check("arst_idle",  64'(DSP_Idle),      64'd1);
    check("arst_err",   64'(DSP_Err),       64'd0);
    check("arst_stall", 64'(DSP_StallCnt),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- Randomized run against the queue model ------------------------------
    reset_dut();
    for (int i = 0; i < PC; i++) begin
      mq[i].delete();
      mcnt[i] = 0;
    end
    merr   = '0;
    midle  = 1'b1;
    mstall = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic          vld;
      logic [PW-1:0] tag;
      logic [DW-1:0] dat;
      logic [PC-1:0] req, ordy;
      logic          erdy, acc;
      int            t;

      vld = ($urandom_range(0, 2) != 0);
      tag = ($urandom_range(0, 15) == 0) ? PW'($urandom_range(6, 7)) : PW'($urandom_range(0, 5));
      dat = rand_dat();
      for (int i = 0; i < PC; i++) begin
        req[i]  = ($urandom_range(0, 2) == 0);
        ordy[i] = $urandom_range(0, 1) != 0;
      end
      t    = int'(tag);
      erdy = (t >= PC) ? 1'b1 : (mq[t].size() < BD);

      drive(vld, tag, dat, req, ordy);
      check("rnd_rdy",  64'(DSPMIC_OfmRdy), 64'(erdy));
      check("rnd_err",  64'(DSP_Err),       64'(merr));
      check("rnd_idle", 64'(DSP_Idle),      64'(midle));
      for (int i = 0; i < PC; i++) begin
        check($sformatf("rnd_vld%0d", i), 64'(DSPPOL_OfmVld[i]), 64'(mq[i].size() > 0));
        if (mq[i].size() > 0)
          check_dat($sformatf("rnd_dat%0d", i), DSPPOL_Ofm[DW*i +: DW], mq[i][0]);
      end

      // Advance the model by one cycle.
      acc = vld && erdy;
      for (int i = 0; i < PC; i++)
        if (mq[i].size() > 0 && ordy[i]) void'(mq[i].pop_front());
      if (acc) begin
        if (t >= PC) merr[0] = 1'b1;
        else         mq[t].push_back(dat);
      end
      midle = 1'b1;
      for (int i = 0; i < PC; i++) begin
        int n;
        n = mcnt[i] + int'(req[i]) - ((acc && t == i) ? 1 : 0);
        if (n < 0)    begin merr[1] = 1'b1; n = 0;    end
        if (n > CMAX) begin merr[2] = 1'b1; n = CMAX; end
        mcnt[i] = n;
        if (mq[i].size() != 0 || mcnt[i] != 0) midle = 1'b0;
      end
      if (vld && !erdy && mstall < 65535) mstall++;
    end
    idle_cycle('0);
    check("rnd_stall_cnt", 64'(DSP_StallCnt), STALL_EN ? 64'(mstall) : 64'd0);
    check("rnd_err_final", 64'(DSP_Err),      64'(merr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
